ram_fifo_ctrl: RTL
==================

// Module: ram_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller that drives the write and read ports of the simple dual-port RAM (dut) and consumes its registered read data.
//  Converts the RAM into a valid/ready stream FIFO: the push side writes the RAM, and the pop side issues prefetch reads and buffers the returning words.
//  Sits between a streaming producer and consumer; the RAM is instantiated alongside it, with both RAM clocks tied to clk.
// PARAMETERS
//  D_WIDTH  16  data word width; must equal the RAM D_WIDTH
//  A_WIDTH  5   RAM address width; RAM depth DEPTH = 2**A_WIDTH
// PORTS
//  clk             in   1          single clock; also drives the RAM clk_write and clk_read
//  reset           in   1          asynchronous, active-high reset
//  in_valid        in   1          producer has a word
//  in_ready        out  1          FIFO accepts; push = in_valid & in_ready
//  in_data         in   D_WIDTH    push word
//  out_valid       out  1          out_data holds a valid word
//  out_ready       in   1          consumer takes; pop = out_valid & out_ready
//  out_data        out  D_WIDTH    head word
//  fill            out  A_WIDTH+2  total words held (RAM + in-flight read + skid), 0..DEPTH+2
//  address_write   out  A_WIDTH    to RAM: wr_ptr[A_WIDTH-1:0]
//  data_write      out  D_WIDTH    to RAM: in_data (combinational)
//  write_enable    out  1          to RAM: push
//  address_read    out  A_WIDTH    to RAM: rd_ptr[A_WIDTH-1:0]
//  data_read       in   D_WIDTH    from RAM: registered data, valid the cycle after a read issue
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0 (A_WIDTH+1 bits, MSB is wrap bit), rd_pending=0, skid empty.
//   Outputs during reset: out_valid=0, fill=0, in_ready=0, write_enable=0.
//   in_ready=1 from the first cycle after deassertion.
//  Reset mid-operation: all stored, in-flight and skid words are discarded; the data_read returning after reset is ignored.
//  ram_empty = (wr_ptr==rd_ptr); ram_full = (MSBs differ, low bits equal).
//  in_ready = !ram_full & !reset. in_ready has no combinational path from out_ready or pop.
//  Push: RAM written at the clock edge; wr_ptr+1 with natural wrap at 2*DEPTH.
//  Read issue (combinational) when: !ram_empty & (skid_cnt + rd_pending - pop) < 2.
//   Effects: rd_ptr+1; rd_pending<=1 for one cycle.
//   Capture: the cycle after issue, data_read is written into the skid at the edge.
//  Skid: 2-entry in-order buffer. out_data = oldest entry; out_valid = (skid_cnt != 0). out_data is held stable while out_valid & !out_ready.
//  Throughput: one push and one pop per cycle sustained. Back-to-back read issues are allowed.
//  Latency: a word pushed at edge E0 into an empty FIFO gives out_valid=1 after edge E2.
//  Collision: read and write never target the same address in the same cycle (read requires !ram_empty, write requires !ram_full). The RAM read-during-write mode is therefore irrelevant.
//  Simultaneous push and pop: both occur. fill is unchanged when push and pop happen and no other transfer changes the count.
//  fill = (wr_ptr - rd_ptr) + rd_pending + skid_cnt, computed modulo 2**(A_WIDTH+1) for the pointer difference.
//  Full: fill = DEPTH+2 and in_ready=0. Push attempts while full are ignored; no RAM write occurs.
//  Empty: out_valid=0. out_ready is ignored; no state changes.
// STRUCTURE
//  No shared package. Use a local parameter DEPTH = 1<<A_WIDTH.
//  Sub-module ram_fifo_skid: 2-entry valid/ready skid buffer with load, pop and cnt.
//  The top level holds the pointers, read-issue logic and fill computation.
// TESTING (bench instantiates ram_fifo_ctrl + dut, D_WIDTH=16, A_WIDTH=5, clk period 10)
//  1. Reset, then push 0xA5A5 once with out_ready=1 -> out_valid rises after edge E2 with out_data=0xA5A5; fill returns to 0.
//  2. Push 0..33 with out_ready=0 -> in_ready falls after 34 accepted words (fill=34).
//     Then pop all 34 -> output is 0..33 in order, then out_valid=0.
//  3. Continuous push and pop with in_valid=out_ready=1 for 200 cycles -> one word per cycle after the initial latency.
//     Counting sequence intact across pointer wrap; fill stays constant.
//  4. Random in_valid/out_ready (50%) for 5000 words -> output matches scoreboard.
//     Check each cycle: fill never exceeds 34, and out_data stays stable while stalled.
//  5. Assert reset for 1 cycle with 10 words held and a read in flight -> out_valid=0, fill=0.
//     Next push of 0x1234 is the first word popped.
//  6. Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> pop occurs, push is blocked.
//     in_ready rises the next cycle; no RAM write while full (write_enable=0).

Source files
------------

// File: rtl/dut.sv
// Simple dual-port RAM: synchronous write port, registered read port, independent clocks.
// Read data appears the cycle after the read address is presented.
module dut #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic               clk_write,
  input  logic               clk_read,
  input  logic [A_WIDTH-1:0] address_write,
  input  logic [D_WIDTH-1:0] data_write,
  input  logic               write_enable,
  input  logic [A_WIDTH-1:0] address_read,
  output logic [D_WIDTH-1:0] data_read
);

  logic [D_WIDTH-1:0] mem [1<<A_WIDTH];

  always_ff @(posedge clk_write) begin
    if (write_enable) mem[address_write] <= data_write;
  end

  always_ff @(posedge clk_read) begin
    data_read <= mem[address_read];
  end

endmodule

// File: rtl/ram_fifo_ctrl_skid.sv
// Two-entry in-order skid buffer holding words returned from the RAM.
// Entry 0 is always the oldest word; load and pop may happen in the same cycle.
module ram_fifo_ctrl_skid #(
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [D_WIDTH-1:0] load_data,
  input  logic               pop,
  output logic [1:0]         cnt,
  output logic               valid,
  output logic [D_WIDTH-1:0] data
);

  logic [D_WIDTH-1:0] ent0_p0;
  logic [D_WIDTH-1:0] ent1_p0;
  logic [1:0]         slot;

  assign slot  = cnt - {1'b0, pop};
  assign valid = (cnt != 2'd0);
  assign data  = ent0_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= 2'd0;
    else       cnt <= cnt + {1'b0, load} - {1'b0, pop};
  end

  // Data entries carry no reset; cnt alone says which are meaningful.
  always_ff @(posedge clk) begin
    if (pop) ent0_p0 <= ent1_p0;
    if (load) begin
      if (slot == 2'd0) ent0_p0 <= load_data;
      else              ent1_p0 <= load_data;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready stream FIFO built around an external simple dual-port RAM with registered reads.
// Pointers carry a wrap bit; reads are prefetched into a 2-entry skid so pops sustain one per cycle.
module ram_fifo_ctrl #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic [A_WIDTH+1:0] fill,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam int FW    = A_WIDTH + 2;

  logic [A_WIDTH:0] wr_ptr;
  logic [A_WIDTH:0] rd_ptr;
  logic [A_WIDTH:0] ptr_diff;
  logic             rd_pending;
  logic             ram_empty;
  logic             ram_full;
  logic             push;
  logic             pop;
  logic             issue;
  logic [1:0]       skid_cnt;
  logic [2:0]       occ;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[A_WIDTH] != rd_ptr[A_WIDTH]) &&
                     (wr_ptr[A_WIDTH-1:0] == rd_ptr[A_WIDTH-1:0]);

  assign in_ready = !ram_full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Issue a read only if the returning word is guaranteed a free skid slot.
  assign occ   = {1'b0, skid_cnt} + {2'b00, rd_pending};
  assign issue = !ram_empty && (occ < (3'd2 + {2'b00, pop}));

  assign address_write = wr_ptr[A_WIDTH-1:0];
  assign data_write    = in_data;
  assign write_enable  = push;
  assign address_read  = rd_ptr[A_WIDTH-1:0];

  assign ptr_diff = wr_ptr - rd_ptr;
  assign fill     = {1'b0, ptr_diff} + FW'(rd_pending) + FW'(skid_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      rd_pending <= issue;
    end
  end

  // Stage boundary: RAM registered read data lands in the skid the cycle after issue.
  ram_fifo_ctrl_skid #(
    .D_WIDTH(D_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_pending),
    .load_data(data_read),
    .pop      (pop),
    .cnt      (skid_cnt),
    .valid    (out_valid),
    .data     (out_data)
  );

endmodule
